// File: rtl/rgb_pkg.sv
// Shared types and default parameters for the RGB LED PWM sequencer.
package rgb_pkg;

  typedef enum logic [1:0] {
    ST_OFF    = 2'd0,
    ST_SETTLE = 2'd1,
    ST_ON     = 2'd2,
    ST_STOP   = 2'd3
  } state_t;

  localparam int DEF_SETTLE_CYCLES = 2400;
  localparam int DEF_PRESCALE      = 94;
  localparam int DEF_PWM_BITS      = 8;

endpackage

// File: rtl/rgb_pwm_channel.sv
// One PWM channel: holds the active duty and the registered compare output.
module rgb_pwm_channel
  import rgb_pkg::*;
#(
  parameter int PWM_BITS = DEF_PWM_BITS
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                load,
  input  logic                run,
  input  logic [PWM_BITS-1:0] duty_in,
  input  logic [PWM_BITS-1:0] cnt,
  output logic                pwm
);

  logic [PWM_BITS-1:0] duty_reg;
  logic                pwm_reg;

  // The compare uses the duty held before any same-cycle load, so a new
  // duty only takes effect on the output one cycle after the counter wraps.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      duty_reg <= '0;
      pwm_reg  <= 1'b0;
    end else begin
      if (load) duty_reg <= duty_in;
      pwm_reg <= run && (cnt < duty_reg);
    end
  end

  assign pwm = pwm_reg;

endmodule

// File: rtl/rgb_pwm_sequencer.sv
// Power sequencing FSM for an RGB LED driver plus a three-channel PWM with
// shadowed duty updates that only land on a PWM period boundary.
module rgb_pwm_sequencer
  import rgb_pkg::*;
#(
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int PRESCALE      = DEF_PRESCALE,
  parameter int PWM_BITS      = DEF_PWM_BITS
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                enable,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [PWM_BITS-1:0] cfg_duty0,
  input  logic [PWM_BITS-1:0] cfg_duty1,
  input  logic [PWM_BITS-1:0] cfg_duty2,
  output logic                curren,
  output logic                rgbleden,
  output logic                pwm0,
  output logic                pwm1,
  output logic                pwm2,
  output logic                active
);

  localparam int              SETTLE_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYCLES - 1);
  localparam logic [15:0]     PRE_LAST    = 16'(PRESCALE - 1);

  state_t              state_reg, state_next;
  logic [SETTLE_W-1:0] settle_cnt_reg, settle_cnt_next;
  logic [15:0]         pre_cnt_reg;
  logic [PWM_BITS-1:0] pwm_cnt_reg;
  logic                pending_reg, pending_next;
  logic                ready_reg;
  logic [PWM_BITS-1:0] shadow_reg [3];
  logic [PWM_BITS-1:0] cfg_duty   [3];
  logic [2:0]          pwm_bus;

  logic in_on, on_next, tick, wrap, accept, load_active;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_OFF:    if (enable) state_next = ST_SETTLE;
      ST_SETTLE: begin
        if (!enable)                   state_next = ST_OFF;
        else if (settle_cnt_reg == '0) state_next = ST_ON;
      end
      ST_ON:     if (!enable) state_next = ST_STOP;
      ST_STOP:   state_next = ST_OFF;
      default:   state_next = ST_OFF;
    endcase
  end

  always_comb begin
    settle_cnt_next = '0;
    if (state_next == ST_SETTLE)
      settle_cnt_next = (state_reg == ST_SETTLE) ? settle_cnt_reg - SETTLE_W'(1) : SETTLE_LOAD;
  end

  assign in_on   = (state_reg == ST_ON);
  assign on_next = (state_next == ST_ON);
  assign tick    = in_on && (pre_cnt_reg == PRE_LAST);
  assign wrap    = tick && (pwm_cnt_reg == '1);
  assign accept  = cfg_valid && ready_reg;

  // Outside ON the shadow may be copied at once, except on the edge that
  // enters ON: the channels would still compare against the old duty there.
  assign load_active = pending_reg && (wrap || (!in_on && !on_next));

  always_comb begin
    pending_next = pending_reg;
    if (accept)           pending_next = 1'b1;
    else if (load_active) pending_next = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg      <= ST_OFF;
      settle_cnt_reg <= '0;
      pre_cnt_reg    <= '0;
      pwm_cnt_reg    <= '0;
      pending_reg    <= 1'b0;
      ready_reg      <= 1'b0;
      for (int i = 0; i < 3; i++) shadow_reg[i] <= '0;
    end else begin
      state_reg      <= state_next;
      settle_cnt_reg <= settle_cnt_next;
      pending_reg    <= pending_next;
      ready_reg      <= !pending_next;
      if (!in_on)    pre_cnt_reg <= '0;
      else if (tick) pre_cnt_reg <= '0;
      else           pre_cnt_reg <= pre_cnt_reg + 16'd1;
      if (!in_on)    pwm_cnt_reg <= '0;
      else if (tick) pwm_cnt_reg <= pwm_cnt_reg + PWM_BITS'(1);
      if (accept)
        for (int i = 0; i < 3; i++) shadow_reg[i] <= cfg_duty[i];
    end
  end

  assign cfg_duty[0] = cfg_duty0;
  assign cfg_duty[1] = cfg_duty1;
  assign cfg_duty[2] = cfg_duty2;

  for (genvar gi = 0; gi < 3; gi++) begin : g_ch
    rgb_pwm_channel #(
      .PWM_BITS(PWM_BITS)
    ) u_ch (
      .clk     (clk),
      .resetn  (resetn),
      .load    (load_active),
      .run     (on_next),
      .duty_in (shadow_reg[gi]),
      .cnt     (pwm_cnt_reg),
      .pwm     (pwm_bus[gi])
    );
  end

  assign cfg_ready = ready_reg;
  assign curren    = (state_reg != ST_OFF);
  assign rgbleden  = in_on;
  assign active    = in_on;
  assign pwm0      = pwm_bus[0];
  assign pwm1      = pwm_bus[1];
  assign pwm2      = pwm_bus[2];

endmodule

// File: tb/tb_rgb_pwm_sequencer.sv
// Directed bench: reset/handshake vector table, then hand-written sequences
// for settle timing, PWM duty, boundary-aligned duty updates, stop and reset.
module tb_rgb_pwm_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       resetn, enable, cfg_valid;
  logic [7:0] cfg_duty0, cfg_duty1, cfg_duty2;
  logic       cfg_ready, curren, rgbleden, pwm0, pwm1, pwm2, active;
  logic       p_ready, p_curren, p_rgbleden, p_pwm0, p_pwm1, p_pwm2, p_active;

  int checks = 0;
  int errors = 0;

  rgb_pwm_sequencer #(.SETTLE_CYCLES(2400), .PRESCALE(1), .PWM_BITS(8)) u_dut (
    .clk(clk), .resetn(resetn), .enable(enable), .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready), .cfg_duty0(cfg_duty0), .cfg_duty1(cfg_duty1),
    .cfg_duty2(cfg_duty2), .curren(curren), .rgbleden(rgbleden),
    .pwm0(pwm0), .pwm1(pwm1), .pwm2(pwm2), .active(active)
  );

  // Second instance with a slower prescaler, driven by the same stimulus.
  rgb_pwm_sequencer #(.SETTLE_CYCLES(2400), .PRESCALE(3), .PWM_BITS(8)) u_dut_p (
    .clk(clk), .resetn(resetn), .enable(enable), .cfg_valid(cfg_valid),
    .cfg_ready(p_ready), .cfg_duty0(cfg_duty0), .cfg_duty1(cfg_duty1),
    .cfg_duty2(cfg_duty2), .curren(p_curren), .rgbleden(p_rgbleden),
    .pwm0(p_pwm0), .pwm1(p_pwm1), .pwm2(p_pwm2), .active(p_active)
  );

  typedef struct {
    logic       resetn, enable, valid;
    logic [7:0] d0, d1, d2;
    logic       curren, rgbleden, active, ready;
    logic [2:0] pwm;
  } vec_t;

  vec_t vecs [5];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic settle_count(output int n);
    enable = 1'b1;
    step();
    check("curren_after_enable", curren, 1);
    n = 0;
    while (!rgbleden && n < 3000) begin
      step();
      n++;
    end
    $display("settle: rgbleden after %0d cycles", n);
  endtask

  initial begin
    int n, hi, leak, c0, c1, c2, q0, q2;
    logic prev, found;

    vecs[0] = '{1'b0, 1'b0, 1'b0, 8'd0,  8'd0, 8'd0,   1'b0, 1'b0, 1'b0, 1'b0, 3'b000};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 8'd0,  8'd0, 8'd0,   1'b0, 1'b0, 1'b0, 1'b1, 3'b000};
    vecs[2] = '{1'b1, 1'b0, 1'b1, 8'd64, 8'd0, 8'd255, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 8'd0,  8'd0, 8'd0,   1'b0, 1'b0, 1'b0, 1'b1, 3'b000};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 8'd9,  8'd9, 8'd9,   1'b0, 1'b0, 1'b0, 1'b1, 3'b000};

    resetn = 1'b0; enable = 1'b0; cfg_valid = 1'b0;
    cfg_duty0 = '0; cfg_duty1 = '0; cfg_duty2 = '0;

    for (int i = 0; i < 5; i++) begin
      resetn = vecs[i].resetn; enable = vecs[i].enable; cfg_valid = vecs[i].valid;
      cfg_duty0 = vecs[i].d0; cfg_duty1 = vecs[i].d1; cfg_duty2 = vecs[i].d2;
      step();
      check($sformatf("v%0d_curren", i),   curren,   vecs[i].curren);
      check($sformatf("v%0d_rgbleden", i), rgbleden, vecs[i].rgbleden);
      check($sformatf("v%0d_active", i),   active,   vecs[i].active);
      check($sformatf("v%0d_ready", i),    cfg_ready, vecs[i].ready);
      check($sformatf("v%0d_pwm", i),      {pwm0, pwm1, pwm2}, vecs[i].pwm);
      $display("vector %0d: resetn=%0b enable=%0b valid=%0b -> curren=%0b rgbleden=%0b ready=%0b",
               i, resetn, enable, cfg_valid, curren, rgbleden, cfg_ready);
    end
    cfg_valid = 1'b0;

    // Power-up settle timing.
    settle_count(n);
    check("settle_cycles", n, 2400);
    check("active_on", active, 1);
    check("curren_on", curren, 1);

    // Duty 64/0/255 over three full 256-tick periods.
    repeat (10) step();
    c0 = 0; c1 = 0; c2 = 0; q0 = 0; q2 = 0;
    for (int k = 0; k < 768; k++) begin
      step();
      c0 += int'(pwm0); c1 += int'(pwm1); c2 += int'(pwm2);
      q0 += int'(p_pwm0); q2 += int'(p_pwm2);
    end
    $display("window: pwm highs %0d %0d %0d, prescale-3 highs %0d %0d", c0, c1, c2, q0, q2);
    check("pwm0_high_768", c0, 192);
    check("pwm1_high_768", c1, 0);
    check("pwm2_high_768", c2, 765);
    check("p_pwm0_high_768", q0, 192);
    check("p_pwm2_high_768", q2, 765);

    // Duty change 64 -> 200 offered right after pwm0 falls.
    prev = pwm0; found = 1'b0; n = 0;
    while (!found && n < 600) begin
      step();
      n++;
      if (prev && !pwm0) found = 1'b1;
      prev = pwm0;
    end
    check("pwm0_fall_found", found, 1);
    check("ready_before_cfg", cfg_ready, 1);
    cfg_valid = 1'b1; cfg_duty0 = 8'd200; cfg_duty1 = 8'd0; cfg_duty2 = 8'd255;
    step();
    cfg_valid = 1'b0;
    check("ready_drop", cfg_ready, 0);
    n = 0; hi = 0;
    while (!cfg_ready && n < 400) begin
      if (pwm0) hi++;
      n++;
      step();
    end
    $display("duty update: ready low %0d cycles, pwm0 highs meanwhile %0d", n, hi);
    check("ready_low_cycles", n, 190);
    check("old_period_no_high", hi, 0);
    check("pwm0_at_ready", pwm0, 0);
    step();
    check("pwm0_new_period", pwm0, 1);
    n = 0;
    while (pwm0 && n < 300) begin
      n++;
      step();
    end
    $display("duty update: new pwm0 high run %0d", n);
    check("pwm0_high_run_200", n, 200);
    check("pre_stop_pwm2", pwm2, 1);

    // Stop ordering.
    enable = 1'b0;
    step();
    $display("stop: curren=%0b rgbleden=%0b pwm=%0b%0b%0b", curren, rgbleden, pwm0, pwm1, pwm2);
    check("stop_rgbleden", rgbleden, 0);
    check("stop_pwm", {pwm0, pwm1, pwm2}, 3'b000);
    check("stop_curren", curren, 1);
    check("stop_active", active, 0);
    step();
    check("off_curren", curren, 0);

    // Abort in SETTLE after 100 cycles.
    enable = 1'b1;
    step();
    check("abort_curren_up", curren, 1);
    leak = 0;
    repeat (100) begin
      step();
      if (rgbleden) leak++;
    end
    enable = 1'b0;
    step();
    $display("abort: curren=%0b leaks=%0d", curren, leak);
    check("abort_curren_down", curren, 0);
    check("abort_no_rgbleden", leak, 0);

    // Load duty 128 while OFF, then full re-settle.
    cfg_valid = 1'b1; cfg_duty0 = 8'd128; cfg_duty1 = 8'd128; cfg_duty2 = 8'd128;
    step();
    cfg_valid = 1'b0;
    check("off_cfg_ready_drop", cfg_ready, 0);
    step();
    check("off_cfg_copy_ready", cfg_ready, 1);
    settle_count(n);
    check("resettle_cycles", n, 2400);
    found = 1'b0; n = 0;
    while (!found && n < 300) begin
      step();
      n++;
      if (pwm0 && pwm1 && pwm2) found = 1'b1;
    end
    check("duty128_high_seen", found, 1);

    // One-cycle reset while ON.
    resetn = 1'b0; enable = 1'b0;
    step();
    $display("reset: outputs=%07b", {curren, rgbleden, active, pwm0, pwm1, pwm2, cfg_ready});
    check("reset_outputs", {curren, rgbleden, active, pwm0, pwm1, pwm2, cfg_ready}, 7'b0);
    resetn = 1'b1;
    step();
    check("release_ready", cfg_ready, 1);
    check("release_curren", curren, 0);
    settle_count(n);
    check("post_reset_settle", n, 2400);
    repeat (4) step();
    c0 = 0; c1 = 0; c2 = 0;
    for (int k = 0; k < 256; k++) begin
      step();
      c0 += int'(pwm0); c1 += int'(pwm1); c2 += int'(pwm2);
    end
    $display("post reset: pwm highs %0d %0d %0d", c0, c1, c2);
    check("post_reset_duty0", c0, 0);
    check("post_reset_duty1", c1, 0);
    check("post_reset_duty2", c2, 0);
    check("post_reset_active", active, 1);

    enable = 1'b0;
    repeat (3) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
